// File: rtl/tone_period_detector.sv
// tone_period_detector
//   Measures the period (in clk cycles) of an incoming square-wave tone and
//   checks it against TARGET_PERIOD +/- TOLERANCE. Reports every measured
//   period, a match flag, a lock flag after LOCK_COUNT consecutive matches,
//   and a timeout pulse when no rising edge arrives for 2*TARGET_PERIOD cycles.
//
//   Optional build macro: PERIOD_AVG_EN
//     defined   -> period_out is the truncated mean of the last 4 periods, and
//                  reporting starts at the 4th period after WAIT_EDGE
//     undefined -> period_out is the raw single-period measurement
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   measurement enable; low forces IDLE
//   tone_in      in   asynchronous square-wave input
//   period_out   out  last measured (or averaged) period, CNT_W bits
//   period_valid out  one-cycle pulse when period_out updates
//   match        out  last period within TARGET_PERIOD +/- TOLERANCE
//   locked       out  LOCK_COUNT consecutive matches, no mismatch/timeout since
//   timeout      out  one-cycle pulse on 2*TARGET_PERIOD cycles without an edge
module tone_period_detector #(
  parameter int unsigned TARGET_PERIOD = 97122,
  parameter int unsigned TOLERANCE     = 1000,
  parameter int unsigned GLITCH_LEN    = 16,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned CNT_W         = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             match,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned GL_W = (GLITCH_LEN > 2) ? $clog2(GLITCH_LEN) : 1;
  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 * TARGET_PERIOD);
  localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(TARGET_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(TARGET_PERIOD + TOLERANCE);
  localparam logic [GL_W-1:0]  GL_LAST = GL_W'(GLITCH_LEN - 1);
  localparam logic [MC_W-1:0]  MC_MAX  = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]  MC_PRE  = MC_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_MEASURE
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_filt;
  logic [GL_W-1:0]   r_fcnt;
  logic              r_rise;
  logic [CNT_W-1:0]  r_cnt;
  logic [MC_W-1:0]   r_mcnt;

  logic [CNT_W-1:0]  w_meas;
  logic              w_report;
  logic              w_match;

  // Synchronizer and glitch filter. The rise strobe is registered in the same
  // cycle the filtered level flips, so edge latency is fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_fcnt  <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == GL_LAST) begin
        r_filt <= ~r_filt;
        r_fcnt <= '0;
        r_rise <= ~r_filt;
      end else begin
        r_fcnt <= r_fcnt + GL_W'(1);
      end
    end
  end

`ifdef PERIOD_AVG_EN
  logic [CNT_W-1:0] r_hist [4];
  logic [CNT_W+1:0] r_sum;
  logic [2:0]       r_hcnt;
  logic [CNT_W+1:0] w_sum_next;
  logic             w_hist_push;
  logic             w_hist_clr;

  // Running sum: add the newest period, drop the oldest. Cleared slots hold 0,
  // so the sum stays exact while the history is filling.
  always_comb begin
    w_sum_next  = r_sum + {2'b00, r_cnt} - {2'b00, r_hist[3]};
    w_meas      = w_sum_next[CNT_W+1:2];
    w_report    = (r_hcnt >= 3'd3);
    w_hist_push = (r_state == S_MEASURE) && enable && r_rise;
    w_hist_clr  = (r_state != S_MEASURE) || !enable ||
                  (!r_rise && (r_cnt == MAX_CNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) r_hist[i] <= '0;
      r_sum  <= '0;
      r_hcnt <= '0;
    end else if (w_hist_clr) begin
      for (int unsigned i = 0; i < 4; i++) r_hist[i] <= '0;
      r_sum  <= '0;
      r_hcnt <= '0;
    end else if (w_hist_push) begin
      r_hist[0] <= r_cnt;
      for (int unsigned i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
      r_sum <= w_sum_next;
      if (r_hcnt != 3'd4) r_hcnt <= r_hcnt + 3'd1;
    end
  end
`else
  always_comb begin
    w_meas   = r_cnt;
    w_report = 1'b1;
  end
`endif

  assign w_match = (w_meas >= LO_LIM) && (w_meas <= HI_LIM);

  // Measurement FSM. A rise takes priority over the timeout check; enable low
  // overrides everything, including a coincident rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mcnt       <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      match        <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_mcnt  <= '0;
        match   <= 1'b0;
        locked  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_WAIT_EDGE;
          end
          S_WAIT_EDGE: begin
            if (r_rise) begin
              r_state <= S_MEASURE;
              r_cnt   <= CNT_W'(1);
            end
          end
          S_MEASURE: begin
            if (r_rise) begin
              r_cnt <= CNT_W'(1);
              if (w_report) begin
                period_out   <= w_meas;
                period_valid <= 1'b1;
                match        <= w_match;
                if (w_match) begin
                  if (r_mcnt != MC_MAX) r_mcnt <= r_mcnt + MC_W'(1);
                  if (r_mcnt >= MC_PRE) locked <= 1'b1;
                end else begin
                  r_mcnt <= '0;
                  locked <= 1'b0;
                end
              end
            end else if (r_cnt == MAX_CNT) begin
              timeout <= 1'b1;
              match   <= 1'b0;
              locked  <= 1'b0;
              r_mcnt  <= '0;
              r_cnt   <= '0;
              r_state <= S_WAIT_EDGE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_period_detector.sv
// Bench for tone_period_detector with scaled-down parameters. Stimulus is a
// square wave built from randomized period lists; expectations come from the
// period list itself (each rise-to-rise gap is the expected measurement).
module tb_tone_period_detector;

  localparam int T   = 200;
  localparam int TOL = 10;
  localparam int GL  = 8;
  localparam int LC  = 4;
  localparam int CW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          tone_in = 1'b0;
  logic [CW-1:0] period_out;
  logic          period_valid;
  logic          match;
  logic          locked;
  logic          timeout;

  tone_period_detector #(
    .TARGET_PERIOD(T),
    .TOLERANCE    (TOL),
    .GLITCH_LEN   (GL),
    .LOCK_COUNT   (LC),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tone_in     (tone_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .match       (match),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_p[$];
  bit obs_m[$];
  bit obs_l[$];
  int obs_vc[$];
  int obs_tc[$];

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      obs_p.push_back(int'(period_out));
      obs_m.push_back(match);
      obs_l.push_back(locked);
      obs_vc.push_back(cyc);
    end
    if (timeout === 1'b1) obs_tc.push_back(cyc);
  end

  int vectors = 0;
  int errors  = 0;
  int prd[$];

  function automatic bit in_tol(int p);
    return (p >= T - TOL) && (p <= T + TOL);
  endfunction

  // Locked after a period when it and the LC-1 before it all matched.
  function automatic bit exp_locked(int i);
    if (i < LC - 1) return 1'b0;
    for (int k = i - LC + 1; k <= i; k++)
      if (!in_tol(prd[k])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int rnd_in_tol();
    return T - TOL + int'($urandom_range(0, 2 * TOL));
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_p.delete(); obs_m.delete(); obs_l.delete();
    obs_vc.delete(); obs_tc.delete();
  endtask

  task automatic restart();
    enable  = 1'b0;
    tone_in = 1'b0;
    wait_cyc(GL + 6);
    enable = 1'b1;
    wait_cyc(3);
    clear_obs();
  endtask

  // One rise per listed period, then a closing rise so every period gets
  // measured; ends with the line low. Periods from glitch_from on carry a
  // short high glitch in the middle of their low phase.
  task automatic play(input int glitch_from);
    int h, l, pos, g;
    for (int i = 0; i < prd.size(); i++) begin
      h = prd[i] / 2;
      l = prd[i] - h;
      tone_in = 1'b1;
      wait_cyc(h);
      tone_in = 1'b0;
      if (i >= glitch_from) begin
        pos = l / 2;
        g   = int'($urandom_range(1, GL - 1));
        wait_cyc(pos);
        tone_in = 1'b1;
        wait_cyc(g);
        tone_in = 1'b0;
        wait_cyc(l - pos - g);
      end else begin
        wait_cyc(l);
      end
    end
    tone_in = 1'b1;
    wait_cyc(T / 2);
    tone_in = 1'b0;
    wait_cyc(GL + 6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    wait_cyc(3);
    vectors++;
    if ({period_out, period_valid, match, locked, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h/%b/%b/%b/%b, expected all 0",
               period_out, period_valid, match, locked, timeout);
    end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_lock();
    prd.delete();
    for (int i = 0; i < 5; i++) prd.push_back(rnd_in_tol());
    restart();
    play(99);
    vectors++;
    if (obs_p.size() !== prd.size()) begin
      errors++;
      $display("FAIL lock_pulses: got %0d, expected %0d", obs_p.size(), prd.size());
    end
    for (int i = 0; i < prd.size() && i < obs_p.size(); i++) begin
      vectors++;
      if (obs_p[i] !== prd[i]) begin
        errors++; $display("FAIL lock_period[%0d]: got %0d, expected %0d", i, obs_p[i], prd[i]);
      end
      vectors++;
      if (obs_m[i] !== in_tol(prd[i])) begin
        errors++; $display("FAIL lock_match[%0d]: got %b, expected %b", i, obs_m[i], in_tol(prd[i]));
      end
      vectors++;
      if (obs_l[i] !== exp_locked(i)) begin
        errors++; $display("FAIL lock_locked[%0d]: got %b, expected %b", i, obs_l[i], exp_locked(i));
      end
    end
  endtask

  task automatic test_tolerance();
    prd = '{T + TOL, T - TOL, T + TOL, T - TOL, T + TOL + 1, T - TOL, T - TOL - 1, T};
    restart();
    play(99);
    vectors++;
    if (obs_p.size() !== prd.size()) begin
      errors++;
      $display("FAIL tol_pulses: got %0d, expected %0d", obs_p.size(), prd.size());
    end
    for (int i = 0; i < prd.size() && i < obs_p.size(); i++) begin
      vectors++;
      if (obs_p[i] !== prd[i]) begin
        errors++; $display("FAIL tol_period[%0d]: got %0d, expected %0d", i, obs_p[i], prd[i]);
      end
      vectors++;
      if (obs_m[i] !== in_tol(prd[i])) begin
        errors++; $display("FAIL tol_match[%0d]: got %b, expected %b", i, obs_m[i], in_tol(prd[i]));
      end
      vectors++;
      if (obs_l[i] !== exp_locked(i)) begin
        errors++; $display("FAIL tol_locked[%0d]: got %b, expected %b", i, obs_l[i], exp_locked(i));
      end
    end
  endtask

  task automatic test_glitch();
    prd.delete();
    for (int i = 0; i < 7; i++) prd.push_back(rnd_in_tol());
    restart();
    play(4);
    vectors++;
    if (obs_p.size() !== prd.size()) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d, expected %0d", obs_p.size(), prd.size());
    end
    for (int i = 0; i < prd.size() && i < obs_p.size(); i++) begin
      vectors++;
      if (obs_p[i] !== prd[i]) begin
        errors++; $display("FAIL glitch_period[%0d]: got %0d, expected %0d", i, obs_p[i], prd[i]);
      end
      vectors++;
      if (obs_l[i] !== exp_locked(i)) begin
        errors++; $display("FAIL glitch_locked[%0d]: got %b, expected %b", i, obs_l[i], exp_locked(i));
      end
    end
  endtask

  task automatic test_timeout();
    int last_p, gap;
    prd.delete();
    for (int i = 0; i < 5; i++) prd.push_back(rnd_in_tol());
    last_p = prd[4];
    restart();
    play(99);
    for (int k = 0; k < 3 * T && obs_tc.size() == 0; k++) wait_cyc(1);
    wait_cyc(3);
    vectors++;
    if (obs_tc.size() !== 1 || obs_vc.size() !== 5) begin
      errors++;
      $display("FAIL timeout_seen: got %0d timeouts %0d pulses, expected 1 and 5",
               obs_tc.size(), obs_vc.size());
    end else begin
      gap = obs_tc[0] - obs_vc[4];
      vectors++;
      if (gap !== 2 * T) begin
        errors++; $display("FAIL timeout_delay: got %0d, expected %0d", gap, 2 * T);
      end
    end
    vectors++;
    if (locked !== 1'b0 || match !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: got locked=%b match=%b, expected 0 0", locked, match);
    end
    vectors++;
    if (int'(period_out) !== last_p) begin
      errors++; $display("FAIL timeout_hold: got %0d, expected %0d", period_out, last_p);
    end
    // Resume: first edge re-arms, then four periods relock.
    clear_obs();
    prd.delete();
    for (int i = 0; i < 4; i++) prd.push_back(rnd_in_tol());
    play(99);
    vectors++;
    if (obs_p.size() !== 4) begin
      errors++; $display("FAIL relock_pulses: got %0d, expected 4", obs_p.size());
    end else begin
      vectors++;
      if (obs_l[2] !== 1'b0 || obs_l[3] !== 1'b1) begin
        errors++; $display("FAIL relock_locked: got %b%b, expected 01", obs_l[2], obs_l[3]);
      end
      vectors++;
      if (obs_p[0] !== prd[0]) begin
        errors++; $display("FAIL relock_period: got %0d, expected %0d", obs_p[0], prd[0]);
      end
    end
  endtask

  task automatic test_enable();
    int held;
    prd.delete();
    for (int i = 0; i < 5; i++) prd.push_back(rnd_in_tol());
    restart();
    play(99);
    held = prd[4];
    enable = 1'b0;
    wait_cyc(2);
    vectors++;
    if (locked !== 1'b0 || match !== 1'b0 || int'(period_out) !== held) begin
      errors++;
      $display("FAIL enable_low: got locked=%b match=%b period=%0d, expected 0 0 %0d",
               locked, match, period_out, held);
    end
    clear_obs();
    prd.delete();
    for (int i = 0; i < 3; i++) prd.push_back(rnd_in_tol());
    play(99);
    wait_cyc(2 * T + 10);
    vectors++;
    if (obs_p.size() !== 0 || obs_tc.size() !== 0) begin
      errors++;
      $display("FAIL enable_quiet: got %0d pulses %0d timeouts, expected 0 0",
               obs_p.size(), obs_tc.size());
    end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    prd.delete();
    for (int i = 0; i < 5; i++) prd.push_back(rnd_in_tol());
    restart();
    play(99);
    tone_in = 1'b1;
    wait_cyc(T / 2);
    tone_in = 1'b0;
    wait_cyc(T / 4);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({period_out, period_valid, match, locked, timeout} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %0h/%b/%b/%b/%b, expected all 0",
               period_out, period_valid, match, locked, timeout);
    end
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(GL + 6);
    clear_obs();
    prd.delete();
    for (int i = 0; i < 3; i++) prd.push_back(rnd_in_tol());
    play(99);
    vectors++;
    if (obs_p.size() !== 3) begin
      errors++; $display("FAIL rst_pulses: got %0d, expected 3", obs_p.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_p[i] !== prd[i]) begin
          errors++; $display("FAIL rst_period[%0d]: got %0d, expected %0d", i, obs_p[i], prd[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tolerance();
    test_glitch();
    test_timeout();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
